// File: rtl/axis_frame_packer_pkg.sv
// axis_frame_packer_pkg: shared sizing helper and output-register state type
package axis_pkg;
  typedef enum logic {EMPTY, HOLD} out_state_t;
  function automatic int clogb2(input int n);
    int b = 0;
    for (int v = n - 1; v > 0; v >>= 1) b++;
    return b;
  endfunction
endpackage

// File: rtl/axis_frame_packer_if.sv
// axis_frame_packer_if: upstream and downstream AXI-Stream signals of the packer
interface axis_frame_packer_if #(parameter int DATA_WIDTH = 32);
  logic                  s_axis_valid;
  logic [DATA_WIDTH-1:0] s_axis_data;
  logic                  s_axis_ready;
  logic                  m_axis_valid;
  logic [DATA_WIDTH-1:0] m_axis_data;
  logic                  m_axis_last;
  logic                  m_axis_ready;
  modport slave (input s_axis_valid, s_axis_data, m_axis_ready,
                 output s_axis_ready, m_axis_valid, m_axis_data, m_axis_last);
  modport master (output s_axis_valid, s_axis_data, m_axis_ready,
                  input s_axis_ready, m_axis_valid, m_axis_data, m_axis_last);
endinterface

// File: rtl/axis_frame_packer_fifo.sv
// axis_sync_fifo: word storage with wrap-bit pointers, full/empty flags and fill level
module axis_sync_fifo import axis_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         axi_clk,
  input  logic                         axi_reset,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [clogb2(FIFO_DEPTH):0]  level
);
  localparam int AW = clogb2(FIFO_DEPTH);
  logic [AW:0]           wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = wr_ptr == rd_ptr;
  assign level   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];
  // storage needs no reset; only the pointers define what is valid
  always_ff @(posedge axi_clk)
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  // pointers advance independently so push and pop may share a cycle
  always_ff @(posedge axi_clk or posedge axi_reset)
    if (axi_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
endmodule

// File: rtl/axis_frame_packer.sv
// axis_frame_packer: FIFO-buffered AXI-Stream stage that marks every FRAME_LEN-th beat as last
// Optional macro AXIS_FRAME_PACKER_FRAME_COUNT_EN adds a 16-bit completed-frame counter output.
module axis_frame_packer import axis_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int FRAME_LEN  = 8
) (
  input  logic                        axi_clk,
  input  logic                        axi_reset,
  axis_frame_packer_if.slave          bus,
`ifdef AXIS_FRAME_PACKER_FRAME_COUNT_EN
  output logic [15:0]                 frame_count,
`endif
  output logic [clogb2(FIFO_DEPTH):0] fifo_level
);
  localparam int BW = clogb2(FRAME_LEN + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_LEN - 1);
  out_state_t            state;
  logic [BW-1:0]         beat_idx;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  full, empty, load;
  assign load              = !empty && (state == EMPTY || bus.m_axis_ready);
  assign bus.s_axis_ready  = !full;
  assign bus.m_axis_valid  = state == HOLD;
  axis_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .axi_clk   (axi_clk),
    .axi_reset (axi_reset),
    .wr_en     (bus.s_axis_valid && !full),
    .wr_data   (bus.s_axis_data),
    .rd_en     (load),
    .rd_data   (rd_data),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );
  // output register: refill whenever it is free or being drained, freeze under back-pressure
  always_ff @(posedge axi_clk or posedge axi_reset)
    if (axi_reset) begin
      state           <= EMPTY;
      bus.m_axis_data <= '0;
      bus.m_axis_last <= 1'b0;
      beat_idx        <= '0;
    end else if (load) begin
      state           <= HOLD;
      bus.m_axis_data <= rd_data;
      bus.m_axis_last <= beat_idx == LAST_BEAT;
      beat_idx        <= beat_idx == LAST_BEAT ? '0 : beat_idx + 1'b1;
    end else if (state == HOLD && bus.m_axis_ready) begin
      state           <= EMPTY;
    end
`ifdef AXIS_FRAME_PACKER_FRAME_COUNT_EN
  // count frames completed on the output handshake, wrapping naturally at 16 bits
  always_ff @(posedge axi_clk or posedge axi_reset)
    if (axi_reset) frame_count <= '0;
    else if (bus.m_axis_valid && bus.m_axis_ready && bus.m_axis_last) frame_count <= frame_count + 1'b1;
`endif
endmodule

// File: tb/tb_axis_frame_packer.sv
// tb_axis_frame_packer: directed checks on a FRAME_LEN=8 instance, random traffic on a FRAME_LEN=5 instance
module tb_axis_frame_packer;
  logic       axi_clk = 1'b0;
  logic       axi_reset = 1'b0;
  logic [3:0] lvl8, lvl5;
  int         checks = 0;
  int         errors = 0;
  axis_frame_packer_if #(.DATA_WIDTH(32)) bus8 ();
  axis_frame_packer_if #(.DATA_WIDTH(32)) bus5 ();
`ifdef AXIS_FRAME_PACKER_FRAME_COUNT_EN
  logic [15:0] fc8, fc5;
`endif
  axis_frame_packer #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .FRAME_LEN(8)) dut8 (
    .axi_clk    (axi_clk),
    .axi_reset  (axi_reset),
    .bus        (bus8),
`ifdef AXIS_FRAME_PACKER_FRAME_COUNT_EN
    .frame_count(fc8),
`endif
    .fifo_level (lvl8)
  );
  axis_frame_packer #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .FRAME_LEN(5)) dut5 (
    .axi_clk    (axi_clk),
    .axi_reset  (axi_reset),
    .bus        (bus5),
`ifdef AXIS_FRAME_PACKER_FRAME_COUNT_EN
    .frame_count(fc5),
`endif
    .fifo_level (lvl5)
  );
  always #5 axi_clk = ~axi_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic stream(input logic [31:0] base, input int n);
    bus8.m_axis_ready = 1'b1;
    for (int i = 0; i <= n; i++) begin
      bus8.s_axis_valid = i < n;
      bus8.s_axis_data  = base + 32'(i);
      step();
      if (i == 0) chk("stream_latency", 32'(bus8.m_axis_valid), 32'd0);
      else begin
        chk("stream_valid", 32'(bus8.m_axis_valid), 32'd1);
        chk("stream_data", bus8.m_axis_data, base + 32'(i - 1));
        chk("stream_last", 32'(bus8.m_axis_last), 32'((i - 1) % 8 == 7));
      end
    end
    bus8.s_axis_valid = 1'b0;
    step();
    chk("stream_drain", 32'(bus8.m_axis_valid), 32'd0);
  endtask

  initial begin
    int tx, rx, cyc;
    bit s_fire;
    logic [31:0] q[$];
    logic [31:0] exp_word;
    bus8.s_axis_valid = 1'b0; bus8.s_axis_data = '0; bus8.m_axis_ready = 1'b0;
    bus5.s_axis_valid = 1'b0; bus5.s_axis_data = '0; bus5.m_axis_ready = 1'b0;
    // reset state, observed before any clock edge
    #1 axi_reset = 1'b1;
    #1;
    chk("rst_valid", 32'(bus8.m_axis_valid), 32'd0);
    chk("rst_last", 32'(bus8.m_axis_last), 32'd0);
    chk("rst_data", bus8.m_axis_data, 32'd0);
    chk("rst_ready", 32'(bus8.s_axis_ready), 32'd1);
    chk("rst_level", 32'(lvl8), 32'd0);
    step(); step();
    axi_reset = 1'b0;
    // back-to-back stream, last on 0x17 and 0x1F
    stream(32'h10, 16);
    // back-pressure: nine words fit (8 in FIFO + output register)
    bus8.m_axis_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus8.s_axis_valid = 1'b1;
      bus8.s_axis_data  = 32'hA0 + 32'(i);
      chk("bp_ready", 32'(bus8.s_axis_ready), 32'(i < 9));
      step();
    end
    bus8.s_axis_valid = 1'b0;
    chk("bp_full_ready", 32'(bus8.s_axis_ready), 32'd0);
    chk("bp_level", 32'(lvl8), 32'd8);
    chk("bp_valid", 32'(bus8.m_axis_valid), 32'd1);
    chk("bp_data", bus8.m_axis_data, 32'hA0);
    step(); step();
    chk("bp_data_stable", bus8.m_axis_data, 32'hA0);
    chk("bp_last_stable", 32'(bus8.m_axis_last), 32'd0);
    // full + pop: word offered during the pop must not be admitted
    bus8.m_axis_ready = 1'b1;
    bus8.s_axis_valid = 1'b1;
    bus8.s_axis_data  = 32'hA9;
    step();
    bus8.m_axis_ready = 1'b0;
    bus8.s_axis_valid = 1'b0;
    chk("pop_data", bus8.m_axis_data, 32'hA1);
    chk("pop_level", 32'(lvl8), 32'd7);
    chk("pop_ready", 32'(bus8.s_axis_ready), 32'd1);
    step();
    chk("pop_level_hold", 32'(lvl8), 32'd7);
    // release: remaining words in order, A7 closes the frame
    bus8.m_axis_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k < 7) begin
        chk("rel_valid", 32'(bus8.m_axis_valid), 32'd1);
        chk("rel_data", bus8.m_axis_data, 32'hA2 + 32'(k));
        chk("rel_last", 32'(bus8.m_axis_last), 32'(k + 2 == 7));
      end else chk("rel_empty", 32'(bus8.m_axis_valid), 32'd0);
    end
    // mid-frame reset discards stored words and restarts beat counting
    for (int i = 0; i < 5; i++) begin
      bus8.s_axis_valid = 1'b1;
      bus8.s_axis_data  = 32'hC0 + 32'(i);
      step();
    end
    bus8.s_axis_valid = 1'b0;
    chk("mid_valid_before", 32'(bus8.m_axis_valid), 32'd1);
    #2 axi_reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus8.m_axis_valid), 32'd0);
    chk("mid_rst_data", bus8.m_axis_data, 32'd0);
    chk("mid_rst_level", 32'(lvl8), 32'd0);
    step();
    axi_reset = 1'b0;
    stream(32'hD0, 8);
    // random valid/ready on the FRAME_LEN=5 instance
    tx = 0; rx = 0; cyc = 0;
    while (rx < 2000 && cyc < 20000) begin
      if (!bus5.s_axis_valid && tx < 2000 && $urandom_range(1) == 1) begin
        bus5.s_axis_valid = 1'b1;
        bus5.s_axis_data  = 32'(tx);
      end
      bus5.m_axis_ready = $urandom_range(1) == 1;
      s_fire = bus5.s_axis_valid && bus5.s_axis_ready;
      if (s_fire) begin
        q.push_back(bus5.s_axis_data);
        tx++;
      end
      if (bus5.m_axis_valid && bus5.m_axis_ready) begin
        if (q.size() > 0) exp_word = q.pop_front();
        else exp_word = 32'hDEAD_BEEF;
        chk("rnd_data", bus5.m_axis_data, exp_word);
        chk("rnd_last", 32'(bus5.m_axis_last), 32'(rx % 5 == 4));
        rx++;
      end
      step();
      cyc++;
      if (s_fire) bus5.s_axis_valid = 1'b0;
    end
    chk("rnd_count", 32'(rx), 32'd2000);
`ifdef AXIS_FRAME_PACKER_FRAME_COUNT_EN
    chk("rnd_frames", 32'(fc5), 32'd400);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
